ifetch_responder: RTL and testbench
===================================

IFETCH_RESPONDER -- requirements
Module: ifetch_responder

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, number of 32-bit instructions returned per accepted request (legal range 1..15).
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, reset: asynchronous assertion, active-low.
REQ-004 SHALL have port rdy_in, input, 1, global ready; low freezes all state.
REQ-005 SHALL have port enable_from_fetcher, input, 1, burst request, held high by the fetcher until end_to_fetcher.
REQ-006 SHALL have port address_from_fetcher, input, 32, byte address of the first instruction, sampled at accept.
REQ-007 SHALL have port reset_from_fetcher, input, 1, abort (rollback) of any burst in progress.
REQ-008 SHALL have port mem_grant_in, input, 1, RAM port granted to this block this cycle.
REQ-009 SHALL have port mem_din, input, 8, RAM read byte, valid the cycle after its address is issued.
REQ-010 SHALL have port mem_a, output, 32, RAM byte address.
REQ-011 SHALL have port mem_rd_out, output, 1, read strobe qualifying mem_a.
REQ-012 SHALL have port inst_to_fetcher, output, 32, assembled instruction.
REQ-013 SHALL have port one_inst_finish_to_fetcher, output, 1, one-cycle pulse: inst_to_fetcher valid.
REQ-014 SHALL have port end_to_fetcher, output, 1, one-cycle pulse: burst complete.

Function
REQ-015 SHALL implement states IDLE, FETCH, DONE; IDLE->FETCH on accept, FETCH->DONE after the BURST_LEN-th instruction is delivered, DONE->IDLE after one cycle.
REQ-016 SHALL accept only in IDLE, with enable_from_fetcher=1, reset_from_fetcher=0, and the armed flag set; the armed flag clears on accept and sets whenever enable_from_fetcher is sampled 0.
REQ-017 In FETCH, SHALL issue one byte address per granted cycle (mem_rd_out=1, mem_a=base+4*inst_cnt+byte_cnt), byte order 0,1,2,3 (little-endian).
REQ-018 SHALL capture mem_din into byte lane byte_cnt_prev[1:0] of the assembly register on the cycle after each issue, regardless of mem_grant_in that cycle.
REQ-019 When mem_grant_in=0, SHALL drive mem_rd_out=0, not advance the address, and resume from the same byte on the next granted cycle.
REQ-020 SHALL assert one_inst_finish_to_fetcher and update inst_to_fetcher in the cycle after byte 3 is captured; inst_to_fetcher holds until the next instruction.
REQ-021 With continuous grant, the first instruction SHALL be delivered 6 cycles after the accept edge and subsequent ones every 4 cycles.
REQ-022 SHALL assert end_to_fetcher in DONE only (1 cycle), never together with one_inst_finish_to_fetcher.
REQ-023 Address arithmetic SHALL be 32-bit modulo 2^32; wrap past 0xFFFFFFFF continues at 0x00000000.
REQ-024 reset_from_fetcher=1 in any state SHALL, at the next edge, enter IDLE, clear counters, discard the in-flight byte, and suppress finish/end pulses; abort has priority over accept, capture and completion in the same cycle.
REQ-025 rdy_in=0 SHALL hold every register and output unchanged; rst_in overrides rdy_in.

Reset
REQ-026 rst_in=0 SHALL immediately force state IDLE, armed=1, counters 0, mem_a=0, mem_rd_out=0, inst_to_fetcher=0, one_inst_finish_to_fetcher=0, end_to_fetcher=0.
REQ-027 Reset mid-burst SHALL discard all partial data; no pulse occurs after reset release until a new accept.

Configuration
REQ-028 Macro IFETCH_ALIGN_CHECK_EN: if defined, an accepted address with [1:0]!=0 SHALL go directly to DONE (end pulse 1 cycle after accept, zero instructions, no RAM access); if undefined, address[1:0] SHALL be ignored (base forced word-aligned).

Verification
REQ-029 Reset, grant=1, enable=1, address=0x00000100, BURST_LEN=8, RAM bytes=index -> 8 finish pulses, first inst 0x03020100 at cycle 6, last 0x1F1E1D1C, end pulse at cycle 35.
REQ-030 Same burst, mem_grant_in=0 for cycles 3-5 -> no mem_rd_out during those cycles, instruction values unchanged, all deliveries delayed 3 cycles.
REQ-031 reset_from_fetcher=1 coincident with the 3rd finish -> that pulse suppressed, no end pulse, IDLE next cycle, mem_rd_out=0.
REQ-032 enable held high after end -> no second burst until enable sampled 0 then 1.
REQ-033 address=0x00000102 -> with IFETCH_ALIGN_CHECK_EN: end 1 cycle after accept, zero finishes; without: burst from 0x00000100.
REQ-034 address=0xFFFFFFF8, BURST_LEN=4 -> mem_a sequence wraps to 0x00000000 after 0xFFFFFFFF; 4 finishes, one end.

Source files
------------

// File: rtl/ifetch_responder.sv
// Purpose : fetches BURST_LEN 32-bit instructions per request from a byte-wide RAM, little-endian.
// Latency : first instruction 6 cycles after accept with continuous grant, then one every 4 cycles.
// Backpr. : mem_grant_in=0 stalls address issue; rdy_in=0 freezes every register.
//
// Ports
//   clk_in / rst_in               clock, asynchronous active-low reset
//   rdy_in                        global stall (low = hold everything)
//   enable_from_fetcher           burst request, held until end_to_fetcher
//   address_from_fetcher          byte address of first instruction, sampled at accept
//   reset_from_fetcher            abort of any burst in progress
//   mem_grant_in, mem_din         RAM grant and read byte (valid one cycle after issue)
//   mem_a, mem_rd_out             RAM byte address and read strobe
//   inst_to_fetcher               assembled instruction, held until the next one
//   one_inst_finish_to_fetcher    one-cycle pulse per delivered instruction
//   end_to_fetcher                one-cycle pulse when the burst is complete
//
// Build option: define IFETCH_ALIGN_CHECK_EN to reject word-misaligned request
// addresses (straight to DONE, no RAM access). Without it the low two address
// bits are ignored and the base is forced word-aligned.

module ifetch_responder #(
    parameter int BURST_LEN = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        enable_from_fetcher,
    input  logic [31:0] address_from_fetcher,
    input  logic        reset_from_fetcher,
    input  logic        mem_grant_in,
    input  logic [7:0]  mem_din,
    output logic [31:0] mem_a,
    output logic        mem_rd_out,
    output logic [31:0] inst_to_fetcher,
    output logic        one_inst_finish_to_fetcher,
    output logic        end_to_fetcher
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counters are 4 bits wide: BURST_LEN is at most 15.
    localparam logic [3:0] LAST = 4'(BURST_LEN);

    state_t      state_q,     state_d;
    logic        armed_q,     armed_d;
    logic [31:0] base_q,      base_d;
    logic [3:0]  issue_inst_q, issue_inst_d;  // instruction index of the next byte to issue
    logic [1:0]  byte_cnt_q,  byte_cnt_d;     // byte within that instruction
    logic        cap_vld_q,   cap_vld_d;      // a read was issued last cycle; mem_din is live now
    logic [1:0]  cap_lane_q,  cap_lane_d;     // byte lane that read belongs to
    logic [31:0] asm_q,       asm_d;          // assembly register
    logic        dlv_pend_q,  dlv_pend_d;     // byte 3 was captured last edge; deliver now
    logic [3:0]  dlv_cnt_q,   dlv_cnt_d;      // instructions delivered in this burst
    logic [31:0] inst_q,      inst_d;
    logic        fin_q,       fin_d;
    logic        end_q,       end_d;

    logic        accept;
    logic        issue_active;

    // Issue is combinational on the grant so a granted cycle is never wasted.
    // The strobe is also qualified by rdy_in: while frozen the capture pipeline
    // cannot record an issue, so no read may be launched.
    assign issue_active = (state_q == FETCH) && (issue_inst_q != LAST);
    assign mem_rd_out   = issue_active && mem_grant_in && rdy_in;
    assign mem_a        = base_q + {26'd0, issue_inst_q, 2'b00} + {30'd0, byte_cnt_q};

    assign accept = (state_q == IDLE) && enable_from_fetcher &&
                    !reset_from_fetcher && armed_q;

    assign inst_to_fetcher            = inst_q;
    assign one_inst_finish_to_fetcher = fin_q;
    assign end_to_fetcher             = end_q;

`ifndef IFETCH_ALIGN_CHECK_EN
    // Low address bits have no function when the base is forced aligned.
    logic unused_addr_lo;
    assign unused_addr_lo = ^address_from_fetcher[1:0];
`endif

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        base_d       = base_q;
        issue_inst_d = issue_inst_q;
        byte_cnt_d   = byte_cnt_q;
        cap_vld_d    = mem_rd_out;
        cap_lane_d   = byte_cnt_q;
        asm_d        = asm_q;
        dlv_pend_d   = 1'b0;
        dlv_cnt_d    = dlv_cnt_q;
        inst_d       = inst_q;
        fin_d        = 1'b0;
        end_d        = 1'b0;

        // Re-arm only after the fetcher has visibly dropped its request, so a
        // request held high across the end pulse cannot start a second burst.
        if (!enable_from_fetcher) begin
            armed_d = 1'b1;
        end

        // Byte capture happens on the cycle after issue, independent of grant.
        if (cap_vld_q) begin
            asm_d[{cap_lane_q, 3'b000} +: 8] = mem_din;
            dlv_pend_d = (cap_lane_q == 2'd3);
        end

        // Delivery one cycle after the top byte lands. A capture into lane 0 of
        // the next instruction may share this edge; inst_d takes the old asm_q.
        if (dlv_pend_q) begin
            inst_d    = asm_q;
            fin_d     = 1'b1;
            dlv_cnt_d = dlv_cnt_q + 4'd1;
        end

        if (mem_rd_out) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                issue_inst_d = issue_inst_q + 4'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    armed_d      = 1'b0;
                    base_d       = {address_from_fetcher[31:2], 2'b00};
                    issue_inst_d = 4'd0;
                    byte_cnt_d   = 2'd0;
                    dlv_cnt_d    = 4'd0;
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (address_from_fetcher[1:0] != 2'b00) begin
                        state_d = DONE;
                        end_d   = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
`else
                    state_d = FETCH;
`endif
                end
            end
            FETCH: begin
                // The last delivery pulse is on the wire; close the burst next.
                if (fin_q && (dlv_cnt_q == LAST)) begin
                    state_d = DONE;
                    end_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over accept, capture and completion in the same cycle.
        if (reset_from_fetcher) begin
            state_d      = IDLE;
            issue_inst_d = 4'd0;
            byte_cnt_d   = 2'd0;
            dlv_cnt_d    = 4'd0;
            cap_vld_d    = 1'b0;
            dlv_pend_d   = 1'b0;
            asm_d        = asm_q;
            inst_d       = inst_q;
            fin_d        = 1'b0;
            end_d        = 1'b0;
            armed_d      = enable_from_fetcher ? armed_q : 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            armed_q      <= 1'b1;
            base_q       <= 32'd0;
            issue_inst_q <= 4'd0;
            byte_cnt_q   <= 2'd0;
            cap_vld_q    <= 1'b0;
            cap_lane_q   <= 2'd0;
            asm_q        <= 32'd0;
            dlv_pend_q   <= 1'b0;
            dlv_cnt_q    <= 4'd0;
            inst_q       <= 32'd0;
            fin_q        <= 1'b0;
            end_q        <= 1'b0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            base_q       <= base_d;
            issue_inst_q <= issue_inst_d;
            byte_cnt_q   <= byte_cnt_d;
            cap_vld_q    <= cap_vld_d;
            cap_lane_q   <= cap_lane_d;
            asm_q        <= asm_d;
            dlv_pend_q   <= dlv_pend_d;
            dlv_cnt_q    <= dlv_cnt_d;
            inst_q       <= inst_d;
            fin_q        <= fin_d;
            end_q        <= end_d;
        end
    end

endmodule

// File: tb/tb_ifetch_responder.sv
// Bench for ifetch_responder: two instances (BURST_LEN 8 and 4) share the
// stimulus, each with its own byte-wide RAM model; `sel` picks which one the
// fetcher talks to and which one is observed.
`timescale 1ns/1ps
module tb_ifetch_responder;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        enable = 1'b0;
    logic        reset_ff = 1'b0;
    logic        grant = 1'b0;
    logic [31:0] address = 32'd0;
    logic        sel = 1'b0;
    logic [7:0]  salt = 8'd0;

    logic [7:0]  din8, din4;
    logic [31:0] a8, a4, i8, i4;
    logic        rd8, rd4, f8, f4, e8, e4;

    int n_checks = 0;
    int n_errors = 0;

    ifetch_responder #(.BURST_LEN(8)) u_dut8 (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .enable_from_fetcher(enable & ~sel), .address_from_fetcher(address),
        .reset_from_fetcher(reset_ff), .mem_grant_in(grant), .mem_din(din8),
        .mem_a(a8), .mem_rd_out(rd8), .inst_to_fetcher(i8),
        .one_inst_finish_to_fetcher(f8), .end_to_fetcher(e8)
    );

    ifetch_responder #(.BURST_LEN(4)) u_dut4 (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .enable_from_fetcher(enable & sel), .address_from_fetcher(address),
        .reset_from_fetcher(reset_ff), .mem_grant_in(grant), .mem_din(din4),
        .mem_a(a4), .mem_rd_out(rd4), .inst_to_fetcher(i4),
        .one_inst_finish_to_fetcher(f4), .end_to_fetcher(e4)
    );

    logic        obs_rd, obs_fin, obs_end;
    logic [31:0] obs_a, obs_inst;
    assign obs_rd   = sel ? rd4 : rd8;
    assign obs_fin  = sel ? f4  : f8;
    assign obs_end  = sel ? e4  : e8;
    assign obs_a    = sel ? a4  : a8;
    assign obs_inst = sel ? i4  : i8;

    // RAM contents: byte at address a is a[7:0] ^ salt (salt 0 gives bytes=index).
    function automatic logic [7:0] mbyte(input logic [31:0] a);
        return a[7:0] ^ salt;
    endfunction

    // RAM answers one cycle after a strobed address; otherwise noise.
    always @(posedge clk_in) begin
        din8 <= rd8 ? mbyte(a8) : 8'($urandom);
        din4 <= rd4 ? mbyte(a4) : 8'($urandom);
    end

    // Instruction i of a burst from aligned base b, little-endian.
    function automatic logic [31:0] exp_inst(input logic [31:0] b, input int i);
        logic [31:0] a;
        a = b + 32'(4 * i);
        return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
    endfunction

    function automatic logic gsched(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return !(c >= 3 && c <= 5);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One burst on the selected instance. Called and returns at #1 after a
    // posedge. Cycle c=0 is the cycle right after the accept edge.
    task automatic run_burst(input string tag, input logic [31:0] addr, input int gmode,
                             input int abort_c, input bit freeze,
                             output int first_c, output int end_c, output int nfin,
                             output logic [31:0] first_i, output logic [31:0] last_i);
        int          n, c, nis, last_fin_c, idx;
        int          iss_c[64];
        logic [31:0] b, held;
        logic        g;
        bit          done;
        n = sel ? 4 : 8;
        b = {addr[31:2], 2'b00};
        first_c = -1; end_c = -1; nfin = 0; nis = 0; last_fin_c = -1;
        first_i = 32'd0; last_i = 32'd0;
        address = addr; enable = 1'b1; grant = 1'b1; reset_ff = 1'b0;
        @(posedge clk_in); #1;
        c = 0; done = 1'b0;
        while (!done) begin
            g = gsched(gmode, c);
            grant = g;
            reset_ff = (c == abort_c);
            @(negedge clk_in);
            if (c != abort_c)
                chk({tag, " rd_strobe"}, 32'(obs_rd), 32'(g && (nis < 4 * n)));
            if (obs_rd) begin
                chk({tag, " mem_a"}, obs_a, b + 32'(nis));
                if (nis < 64) iss_c[nis] = c;
                nis++;
            end
            if (obs_fin) begin
                chk({tag, " fin_in_range"}, 32'(nfin < n), 32'd1);
                chk({tag, " inst"}, obs_inst, exp_inst(b, nfin));
                idx = 4 * nfin + 3;
                chk({tag, " fin_cycle"}, 32'(c), (idx < nis && idx < 64) ? 32'(iss_c[idx] + 3) : 32'hFFFF_FFFF);
                if (nfin == 0) begin
                    first_c = c;
                    first_i = obs_inst;
                end
                last_i = obs_inst;
                last_fin_c = c;
                nfin++;
            end
            if (obs_end) begin
                chk({tag, " end_with_fin"}, 32'(obs_fin), 32'd0);
                chk({tag, " fins_at_end"}, 32'(nfin), 32'(n));
                chk({tag, " end_cycle"}, 32'(c), 32'(last_fin_c + 1));
                end_c = c;
                done = 1'b1;
                if (freeze) begin
                    held = obs_inst;
                    rdy_in = 1'b0;
                    repeat (3) begin
                        @(negedge clk_in);
                        chk({tag, " frz_end"}, 32'(obs_end), 32'd1);
                        chk({tag, " frz_inst"}, obs_inst, held);
                    end
                    rdy_in = 1'b1;
                end
            end
            if (c == abort_c) done = 1'b1;
            if (!done && c >= 200) begin
                chk({tag, " end_seen"}, 32'(done), 32'd1);
                done = 1'b1;
            end
            @(posedge clk_in); #1;
            c++;
        end
        // Request still held high: nothing may restart until it drops.
        grant = 1'b1; reset_ff = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            chk({tag, " quiet_rd"}, 32'(obs_rd), 32'd0);
            chk({tag, " quiet_fin"}, 32'(obs_fin), 32'd0);
            chk({tag, " quiet_end"}, 32'(obs_end), 32'd0);
            @(posedge clk_in); #1;
        end
        enable = 1'b0;
        @(posedge clk_in); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          fc, ec, nf, ab;
        logic [31:0] fi, li;
        bit          fz;

        // Asynchronous reset, checked before any clock edge.
        #2 rst_in = 1'b0;
        #1;
        chk("rst mem_a", a8, 32'd0);
        chk("rst rd", 32'(rd8), 32'd0);
        chk("rst inst", i8, 32'd0);
        chk("rst fin", 32'(f8), 32'd0);
        chk("rst end", 32'(e8), 32'd0);
        chk("rst end4", 32'(e4), 32'd0);
        @(negedge clk_in); @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Basic burst, RAM bytes = index.
        sel = 1'b0; salt = 8'd0;
        run_burst("basic", 32'h0000_0100, 0, -1, 1'b0, fc, ec, nf, fi, li);
        chk("basic first_cycle", 32'(fc), 32'd6);
        chk("basic first_inst", fi, 32'h0302_0100);
        chk("basic last_inst", li, 32'h1F1E_1D1C);
        chk("basic end_cycle", 32'(ec), 32'd35);
        chk("basic nfin", 32'(nf), 32'd8);

        // Grant withheld for cycles 3..5: everything slips 3 cycles.
        run_burst("stall", 32'h0000_0100, 1, -1, 1'b0, fc, ec, nf, fi, li);
        chk("stall first_cycle", 32'(fc), 32'd9);
        chk("stall first_inst", fi, 32'h0302_0100);
        chk("stall last_inst", li, 32'h1F1E_1D1C);
        chk("stall end_cycle", 32'(ec), 32'd38);

        // Abort sampled on the edge that would raise the 3rd finish.
        run_burst("abort", 32'h0000_0100, 0, 13, 1'b0, fc, ec, nf, fi, li);
        chk("abort nfin", 32'(nf), 32'd2);
        chk("abort no_end", 32'(ec), 32'hFFFF_FFFF);

        // Misaligned request: low bits ignored, burst from 0x100.
        run_burst("misalign", 32'h0000_0102, 0, -1, 1'b0, fc, ec, nf, fi, li);
        chk("misalign first_inst", fi, 32'h0302_0100);
        chk("misalign nfin", 32'(nf), 32'd8);
        chk("misalign end_cycle", 32'(ec), 32'd35);

        // Address wrap on the 4-deep instance.
        sel = 1'b1;
        run_burst("wrap", 32'hFFFF_FFF8, 0, -1, 1'b0, fc, ec, nf, fi, li);
        chk("wrap first_inst", fi, 32'hFBFA_F9F8);
        chk("wrap last_inst", li, 32'h0706_0504);
        chk("wrap nfin", 32'(nf), 32'd4);
        chk("wrap end_cycle", 32'(ec), 32'd19);

        // Global stall while the end pulse is up.
        sel = 1'b0; salt = 8'h5A;
        run_burst("freeze", 32'h1234_5670, 0, -1, 1'b1, fc, ec, nf, fi, li);
        chk("freeze nfin", 32'(nf), 32'd8);

        // Reset in the middle of a burst: outputs clear at once, no late pulses.
        salt = 8'd0;
        address = 32'h0000_0200; enable = 1'b1;
        @(posedge clk_in); #1;
        repeat (9) @(posedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        chk("midrst inst", i8, 32'd0);
        chk("midrst mem_a", a8, 32'd0);
        chk("midrst rd", 32'(rd8), 32'd0);
        chk("midrst fin", 32'(f8), 32'd0);
        enable = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (10) begin
            @(negedge clk_in);
            chk("postrst fin", 32'(f8), 32'd0);
            chk("postrst end", 32'(e8), 32'd0);
            chk("postrst rd", 32'(rd8), 32'd0);
        end
        @(posedge clk_in); #1;

        // Randomised bursts: instance, RAM contents, address, grant, abort, freeze.
        for (int t = 0; t < 14; t++) begin
            sel  = 1'($urandom_range(0, 1));
            salt = 8'($urandom);
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 45)) : -1;
            fz   = ($urandom_range(0, 4) == 0);
            run_burst("rand", $urandom, 2, ab, fz, fc, ec, nf, fi, li);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
